// File: rtl/pipe_add.sv
// pipe_add: pipelined two's-complement adder/subtractor.
// The operand is resolved CHUNK bits per stage, LSB slice first; the slice
// carry is registered between stages. Every stage is an elastic register with
// a valid bit, so the chain streams one result per cycle and stalls without
// loss under backpressure.
module pipe_add #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             sub_i,
  output logic             valid_o,
  input  logic             ready_i,
  output logic [WIDTH-1:0] sum_o,
  output logic             carry_o,
  output logic             overflow_o
);

  localparam int unsigned STAGES = WIDTH / CHUNK;

  // Stage registers. B is stored already inverted for subtraction, and the
  // registered carry doubles as the carry-in (1 for subtraction at stage 0),
  // so the add/sub mode needs no separate pipeline bit.
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  r_q [STAGES];
  logic              ovf_q;

  // Stage inputs (previous stage register, or the ports for stage 0).
  logic [WIDTH-1:0]  a_in  [STAGES];
  logic [WIDTH-1:0]  b_in  [STAGES];
  logic [WIDTH-1:0]  r_in  [STAGES];
  logic [STAGES-1:0] c_in;
  logic [STAGES-1:0] v_in;

  // Stage results.
  logic [CHUNK:0]    part  [STAGES];
  logic [WIDTH-1:0]  r_nxt [STAGES];
  logic [STAGES-1:0] c_nxt;
  logic              ovf_nxt;
  logic [STAGES-1:0] load;

  // Route each stage's inputs from the previous stage or the input ports.
  always_comb begin
    a_in[0] = a_i;
    b_in[0] = sub_i ? ~b_i : b_i;
    c_in[0] = sub_i;
    v_in[0] = valid_i;
    r_in[0] = '0;
    for (int unsigned k = 1; k < STAGES; k++) begin
      a_in[k] = a_q[k-1];
      b_in[k] = b_q[k-1];
      c_in[k] = c_q[k-1];
      v_in[k] = v_q[k-1];
      r_in[k] = r_q[k-1];
    end
  end

  // Resolve slice k in stage k and merge it into the finished low bits.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      part[k]  = {1'b0, a_in[k][k*CHUNK +: CHUNK]}
               + {1'b0, b_in[k][k*CHUNK +: CHUNK]}
               + {{CHUNK{1'b0}}, c_in[k]};
      r_nxt[k] = r_in[k];
      r_nxt[k][k*CHUNK +: CHUNK] = part[k][CHUNK-1:0];
      c_nxt[k] = part[k][CHUNK];
    end
    // Carry into the MSB is recovered from the MSB sum bit and its operands.
    ovf_nxt = part[STAGES-1][CHUNK] ^ part[STAGES-1][CHUNK-1]
            ^ a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1];
  end

  // Elastic load chain: a stage loads if it or any stage above it is empty,
  // or if the output is being consumed.
  always_comb begin
    for (int unsigned k = 0; k < STAGES; k++) begin
      load[k] = ready_i || (((~v_q) >> k) != '0);
    end
  end

  // Stage registers; payload only updates on valid loads so a stage (and the
  // output) keeps its last data across bubbles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_q   <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int unsigned k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        r_q[k] <= '0;
      end
    end else begin
      for (int unsigned k = 0; k < STAGES; k++) begin
        if (load[k]) begin
          v_q[k] <= v_in[k];
          if (v_in[k]) begin
            a_q[k] <= a_in[k];
            b_q[k] <= b_in[k];
            r_q[k] <= r_nxt[k];
            c_q[k] <= c_nxt[k];
          end
        end
      end
      if (load[STAGES-1] && v_in[STAGES-1]) begin
        ovf_q <= ovf_nxt;
      end
    end
  end

  assign ready_o    = load[0];
  assign valid_o    = v_q[STAGES-1];
  assign sum_o      = r_q[STAGES-1];
  assign carry_o    = c_q[STAGES-1];
  assign overflow_o = ovf_q;

endmodule

// File: tb/tb_pipe_add.sv
// tb_pipe_add: randomized and directed checks of pipe_add against an
// arithmetic reference model and an in-order scoreboard.
module tb_pipe_add;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_i;
  logic        ready_i;
  logic [15:0] a;
  logic [15:0] b;
  logic        sub;

  logic        ready_o, valid_o, carry_o, overflow_o;
  logic [15:0] sum_o;
  logic        r1_ready, r1_valid, r1_carry, r1_ovf;
  logic [15:0] r1_sum;

  int nchk = 0;
  int nerr = 0;
  int cyc = 0;
  int nout = 0;
  int first_out = -1;
  int last_out = -1;
  bit last_acc;
  bit prev_stall = 1'b0;
  logic [31:0] snap;
  logic [17:0] expq [$];

  always #5 clk = ~clk;

  pipe_add #(.WIDTH(16), .CHUNK(4)) dut (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(ready_o),
    .a_i(a), .b_i(b), .sub_i(sub), .valid_o(valid_o), .ready_i(ready_i),
    .sum_o(sum_o), .carry_o(carry_o), .overflow_o(overflow_o)
  );

  pipe_add #(.WIDTH(16), .CHUNK(16)) dut1 (
    .clk_i(clk), .rst_i(rst), .valid_i(valid_i), .ready_o(r1_ready),
    .a_i(a), .b_i(b), .sub_i(sub), .valid_o(r1_valid), .ready_i(ready_i),
    .sum_o(r1_sum), .carry_o(r1_carry), .overflow_o(r1_ovf)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic; returns {overflow, carry, sum}.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y, input logic s);
    int sx, sy, ux, uy, r;
    logic c;
    logic [15:0] res;
    sx = $signed(x);
    sy = $signed(y);
    ux = x;
    uy = y;
    if (s) begin
      r = sx - sy;
      c = (ux >= uy);
      res = 16'(ux - uy);
    end else begin
      r = sx + sy;
      c = (ux + uy) > 65535;
      res = 16'(ux + uy);
    end
    return {(r > 32767) || (r < -32768), c, res};
  endfunction

  // One clock: sample handshakes before the edge, score, advance to negedge.
  task automatic tick();
    logic [17:0] e;
    logic [31:0] cur;
    bit outx;
    #1;
    cur = {13'd0, valid_o, carry_o, overflow_o, sum_o};
    if (prev_stall) check("stall_hold", cur, snap);
    prev_stall = valid_o && !ready_i;
    snap = cur;
    outx = valid_o && ready_i;
    last_acc = valid_i && ready_o;
    if (outx) begin
      check("out_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        check("sum", {16'd0, sum_o}, {16'd0, e[15:0]});
        check("carry", {31'd0, carry_o}, {31'd0, e[16]});
        check("ovf", {31'd0, overflow_o}, {31'd0, e[17]});
      end
      nout++;
      if (first_out < 0) first_out = cyc;
      last_out = cyc;
    end
    if (last_acc) expq.push_back(model(a, b, sub));
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic drain();
    int n = 0;
    while (expq.size() > 0 && n < 100) begin
      tick();
      n++;
    end
    check("drain_empty", expq.size(), 0);
  endtask

  task automatic directed(input logic [15:0] x, input logic [15:0] y, input logic s,
                          input logic [15:0] es, input logic ec, input logic eo);
    int lat;
    ready_i = 1'b1;
    valid_i = 1'b1; a = x; b = y; sub = s;
    tick();
    check("dir_accept", {31'd0, last_acc}, 32'd1);
    valid_i = 1'b0;
    lat = 1;
    while (!valid_o && lat < 20) begin
      tick();
      lat++;
    end
    check("dir_latency", lat, 4);
    check("dir_sum", {16'd0, sum_o}, {16'd0, es});
    check("dir_carry", {31'd0, carry_o}, {31'd0, ec});
    check("dir_ovf", {31'd0, overflow_o}, {31'd0, eo});
    drain();
  endtask

  function automatic logic [15:0] pick();
    case ($urandom_range(0, 7))
      0: return 16'hFFFF;
      1: return 16'h8000;
      2: return 16'h7FFF;
      3: return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    int n0;
    logic [15:0] held;
    rst = 1'b1; valid_i = 1'b0; ready_i = 1'b1; a = '0; b = '0; sub = 1'b0;
    #2;
    check("rst_valid", {31'd0, valid_o}, 32'd0);
    check("rst_sum", {16'd0, sum_o}, 32'd0);
    check("rst_carry", {31'd0, carry_o}, 32'd0);
    check("rst_ovf", {31'd0, overflow_o}, 32'd0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1 check("rst_ready", {31'd0, ready_o}, 32'd1);
    @(negedge clk);

    directed(16'h00FF, 16'h0001, 1'b0, 16'h0100, 1'b0, 1'b0);
    directed(16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    directed(16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    directed(16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    directed(16'h8000, 16'h0001, 1'b1, 16'h7FFF, 1'b1, 1'b1);

    // Back-to-back mixed-mode streaming.
    first_out = -1; n0 = nout;
    for (int i = 0; i < 10; i++) begin
      valid_i = 1'b1; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
      tick();
      check("stream_accept", {31'd0, last_acc}, 32'd1);
    end
    valid_i = 1'b0;
    drain();
    check("stream_count", nout - n0, 10);
    check("stream_consecutive", last_out - first_out, 9);

    // Backpressure: pipeline of 4 fills, then ready_o must drop.
    n0 = nout;
    ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      valid_i = 1'b1; a = 16'h1000 + 16'(i); b = 16'($urandom); sub = 1'(i);
      tick();
      check("bp_accept", {31'd0, last_acc}, 32'd1);
    end
    valid_i = 1'b1; a = 16'h2222; b = 16'h0101; sub = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("bp_ready_low", {31'd0, ready_o}, 32'd0);
      check("bp_not_accepted", {31'd0, last_acc}, 32'd0);
      check("bp_valid_held", {31'd0, valid_o}, 32'd1);
    end
    ready_i = 1'b1;
    tick();
    check("bp_accept5", {31'd0, last_acc}, 32'd1);
    a = 16'h3333; b = 16'h4444; sub = 1'b0;
    tick();
    check("bp_accept6", {31'd0, last_acc}, 32'd1);
    valid_i = 1'b0;
    drain();
    check("bp_count", nout - n0, 6);

    // Random traffic with random backpressure.
    for (int i = 0; i < 400; i++) begin
      valid_i = ($urandom_range(0, 3) != 0);
      ready_i = ($urandom_range(0, 3) != 0);
      a = pick(); b = pick(); sub = 1'($urandom);
      tick();
    end
    valid_i = 1'b0; ready_i = 1'b1;
    drain();

    // Reset with three in flight and a result waiting at the output.
    ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      valid_i = 1'b1; a = 16'h0F00 + 16'(i); b = 16'h0011; sub = 1'b0;
      tick();
    end
    valid_i = 1'b0;
    tick();
    check("pre_rst_valid", {31'd0, valid_o}, 32'd1);
    held = sum_o;
    check("pre_rst_sum", {16'd0, held}, 32'h0F11);
    #2 rst = 1'b1;
    #1;
    check("midrst_valid", {31'd0, valid_o}, 32'd0);
    check("midrst_sum", {16'd0, sum_o}, 32'd0);
    check("midrst_carry", {31'd0, carry_o}, 32'd0);
    expq.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      check("no_stale", {31'd0, valid_o}, 32'd0);
    end
    directed(16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);

    // Single-stage instance: latency 1.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    expq.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    valid_i = 1'b1; a = 16'hFFFF; b = 16'h0001; sub = 1'b0; ready_i = 1'b1;
    #1 check("c16_ready", {31'd0, r1_ready}, 32'd1);
    check("c16_idle", {31'd0, r1_valid}, 32'd0);
    tick();
    valid_i = 1'b0;
    check("c16_valid", {31'd0, r1_valid}, 32'd1);
    check("c16_sum", {16'd0, r1_sum}, 32'd0);
    check("c16_carry", {31'd0, r1_carry}, 32'd1);
    check("c16_ovf", {31'd0, r1_ovf}, 32'd0);
    drain();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
